// File: rtl/mac_pkg.sv
// Shared definitions for the multi-lane MAC.
// Holds the job FSM state type, the mode encodings, the lane data width and the
// int/fp16 multiply and add units used by every lane.
package mac_pkg;

  localparam int unsigned DATA_W = 16;

  localparam logic MODE_INT = 1'b0;
  localparam logic MODE_FP  = 1'b1;

  localparam logic [15:0] FP_QNAN = 16'h7E00;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  // Right shift that ORs every bit shifted out into bit 0 (sticky bit).
  function automatic logic [31:0] shr_sticky(input logic [31:0] m, input int unsigned sh);
    logic [31:0] mask;
    if (sh == 0) return m;
    if (sh >= 32) return {31'd0, |m};
    mask = (32'd1 << sh) - 32'd1;
    return (m >> sh) | {31'd0, |(m & mask)};
  endfunction

  // Round-to-nearest-even and pack. Value represented is m * 2^(e - 45), so a
  // leading one at bit 30 with e in 1..30 is an ordinary normal number.
  function automatic logic [15:0] fp16_pack(input logic s, input int e, input logic [31:0] m);
    int          lead;
    int          ee;
    logic [31:0] mm;
    logic [11:0] sig;
    logic        guard;
    logic        sticky;
    if (m == 32'd0) return {s, 15'd0};
    lead = 0;
    for (int i = 0; i < 32; i++) begin
      if (m[i]) lead = i;
    end
    if (lead > 30) begin
      mm = shr_sticky(m, 1);
      ee = e + 1;
    end else begin
      mm = m << (30 - lead);
      ee = e - (30 - lead);
    end
    // Below the normal range: denormalise, the exponent field then encodes 0.
    if (ee < 1) begin
      mm = shr_sticky(mm, unsigned'(1 - ee));
      ee = 1;
    end
    sig    = {1'b0, mm[30:20]};
    guard  = mm[19];
    sticky = |mm[18:0];
    if (guard && (sticky || sig[0])) sig = sig + 12'd1;
    if (sig[11]) begin
      sig = sig >> 1;
      ee  = ee + 1;
    end
    if (ee >= 31) return {s, 5'h1f, 10'd0};
    // A denormal that rounded up into the hidden bit becomes the smallest normal.
    return {s, (sig[10] ? ee[4:0] : 5'd0), sig[9:0]};
  endfunction

  function automatic logic [10:0] fp16_sig(input logic [15:0] x);
    return {|x[14:10], x[9:0]};
  endfunction

  function automatic int fp16_exp(input logic [15:0] x);
    return (x[14:10] == 5'd0) ? 1 : int'(x[14:10]);
  endfunction

  function automatic logic fp16_is_nan(input logic [15:0] x);
    return (x[14:10] == 5'h1f) && (x[9:0] != 10'd0);
  endfunction

  function automatic logic fp16_is_inf(input logic [15:0] x);
    return (x[14:10] == 5'h1f) && (x[9:0] == 10'd0);
  endfunction

  function automatic logic [15:0] int_fp_mul(input logic mode, input logic [15:0] a,
                                             input logic [15:0] b);
    logic        s;
    logic        a_zero;
    logic        b_zero;
    logic [21:0] p;
    if (mode == MODE_INT) return a * b;
    s      = a[15] ^ b[15];
    a_zero = (a[14:0] == 15'd0);
    b_zero = (b[14:0] == 15'd0);
    if (fp16_is_nan(a) || fp16_is_nan(b) || (fp16_is_inf(a) && b_zero) ||
        (fp16_is_inf(b) && a_zero)) return FP_QNAN;
    if (fp16_is_inf(a) || fp16_is_inf(b)) return {s, 5'h1f, 10'd0};
    if (a_zero || b_zero) return {s, 15'd0};
    p = {11'd0, fp16_sig(a)} * {11'd0, fp16_sig(b)};
    return fp16_pack(s, fp16_exp(a) + fp16_exp(b) - 5, {10'd0, p});
  endfunction

  function automatic logic [15:0] int_fp_add(input logic mode, input logic [15:0] a,
                                             input logic [15:0] b);
    int          ea;
    int          eb;
    int          e;
    logic [31:0] ma;
    logic [31:0] mb;
    if (mode == MODE_INT) return a + b;
    if (fp16_is_nan(a) || fp16_is_nan(b)) return FP_QNAN;
    if (fp16_is_inf(a) && fp16_is_inf(b)) return (a[15] == b[15]) ? a : FP_QNAN;
    if (fp16_is_inf(a)) return a;
    if (fp16_is_inf(b)) return b;
    if ((a[14:0] == 15'd0) && (b[14:0] == 15'd0)) return {a[15] & b[15], 15'd0};
    if (a[14:0] == 15'd0) return b;
    if (b[14:0] == 15'd0) return a;
    ea = fp16_exp(a);
    eb = fp16_exp(b);
    ma = {1'b0, fp16_sig(a), 20'd0};
    mb = {1'b0, fp16_sig(b), 20'd0};
    if (ea >= eb) begin
      mb = shr_sticky(mb, unsigned'(ea - eb));
      e  = ea;
    end else begin
      ma = shr_sticky(ma, unsigned'(eb - ea));
      e  = eb;
    end
    if (a[15] == b[15]) return fp16_pack(a[15], e, ma + mb);
    if (ma == mb) return 16'h0000;
    if (ma > mb) return fp16_pack(a[15], e, ma - mb);
    return fp16_pack(b[15], e, mb - ma);
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: operand registers, accumulator and the int/fp16 mul/add units.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   mode_i     0 = INT16, 1 = FP16
//   clr_i      clear operands and accumulator (job start)
//   load_i     load operands from a_i/b_i
//   zero_i     load zero operands (idle beat)
//   acc_en_i   accumulate the product of the current operand registers
//   acc_o      accumulator value
module mac_lane
  import mac_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mode_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              zero_i,
  input  logic              acc_en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] acc_o
);

  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [DATA_W-1:0] prod, sum;
  logic              prod_zero;

  always_comb begin
    prod      = int_fp_mul(mode_i, a_q, b_q);
    sum       = int_fp_add(mode_i, prod, acc_q);
    // Either signed zero must leave the accumulator bit-exact (e.g. -0 stays -0).
    prod_zero = (mode_i == MODE_FP) ? (prod[14:0] == 15'd0) : (prod == '0);
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    if (clr_i) begin
      a_d   = '0;
      b_d   = '0;
      acc_d = '0;
    end else begin
      if (acc_en_i && !prod_zero) acc_d = sum;
      if (load_i) begin
        a_d = a_i;
        b_d = b_i;
      end else if (zero_i) begin
        a_d = '0;
        b_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/mac_vec_seq.sv
// Job-based multi-lane multiply-accumulate.
// A cfg handshake starts a job of cfg_len beats in the latched mode; every lane
// accumulates a*b in lockstep and the result is offered on the out channel.
// Ports:
//   clk, rst                       clock and asynchronous active-high reset
//   cfg_valid/cfg_ready            job request (accepted only when idle)
//   cfg_mode, cfg_len              job mode (1 = FP16) and beat count
//   in_valid/in_ready, in_a, in_b  operand beats, lane i at [16i+15:16i]
//   out_valid/out_ready, out_data  accumulators, zero unless out_valid
//   busy                           high whenever not idle
module mac_vec_seq
  import mac_pkg::*;
#(
  parameter int unsigned LANES  = 4,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic                    cfg_mode,
  input  logic [LEN_W-1:0]        cfg_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_a,
  input  logic [LANES*DATA_W-1:0] in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic                    busy
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d, cnt_inc;
  logic             mode_q, mode_d;
  logic             cfg_ready_q, in_ready_q, out_valid_q, busy_q;
  logic             lane_clr, lane_load, lane_zero, lane_acc_en;

  logic [LANES*DATA_W-1:0] acc_all;

  assign cnt_inc = cnt_q + LEN_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    mode_d      = mode_q;
    lane_clr    = 1'b0;
    lane_load   = 1'b0;
    lane_zero   = 1'b0;
    lane_acc_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cfg_valid) begin
          mode_d   = cfg_mode;
          len_d    = cfg_len;
          cnt_d    = '0;
          lane_clr = 1'b1;
          state_d  = (cfg_len == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        // Accumulate the previous beat while the current beat is captured.
        lane_acc_en = 1'b1;
        if (in_valid) begin
          lane_load = 1'b1;
          cnt_d     = cnt_inc;
          if (cnt_inc == len_q) state_d = StDrain;
        end else begin
          lane_zero = 1'b1;
        end
      end
      StDrain: begin
        lane_acc_en = 1'b1;
        lane_zero   = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      len_q       <= '0;
      mode_q      <= MODE_INT;
      cfg_ready_q <= 1'b1;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      cfg_ready_q <= (state_d == StIdle);
      in_ready_q  <= (state_d == StRun);
      out_valid_q <= (state_d == StDone);
      busy_q      <= (state_d != StIdle);
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_lane u_lane (
      .clk      (clk),
      .rst      (rst),
      .mode_i   (mode_q),
      .clr_i    (lane_clr),
      .load_i   (lane_load),
      .zero_i   (lane_zero),
      .acc_en_i (lane_acc_en),
      .a_i      (in_a[i*DATA_W +: DATA_W]),
      .b_i      (in_b[i*DATA_W +: DATA_W]),
      .acc_o    (acc_all[i*DATA_W +: DATA_W])
    );
  end

  assign cfg_ready = cfg_ready_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = out_valid_q ? acc_all : '0;

endmodule

// File: tb/tb_mac_vec_seq.sv
// Scoreboard bench for mac_vec_seq: stimulus pushes expected results, a monitor
// pops and compares on every output handshake.
module tb_mac_vec_seq;

  localparam int unsigned LANES = 4;
  localparam int unsigned LEN_W = 8;
  localparam int unsigned DW    = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cfg_valid, cfg_ready, cfg_mode;
  logic [LEN_W-1:0]     cfg_len;
  logic                 in_valid, in_ready;
  logic [LANES*DW-1:0]  in_a, in_b;
  logic                 out_valid, out_ready;
  logic [LANES*DW-1:0]  out_data;
  logic                 busy;

  int n_total = 0;
  int n_bad   = 0;

  logic [LANES*DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  mac_vec_seq #(
    .LANES  (LANES),
    .LEN_W  (LEN_W),
    .DATA_W (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_mode  (cfg_mode),
    .cfg_len   (cfg_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic logic [63:0] rep(input logic [15:0] x);
    return {4{x}};
  endfunction

  // Monitor: compare each delivered result against the oldest expectation.
  initial begin
    logic [LANES*DW-1:0] want;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL result_unexpected got=%h want=none", out_data);
        end else begin
          want = exp_q.pop_front();
          chk("result", out_data, want);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  // Caller sits just after a rising edge.
  task automatic do_cfg(input logic mode, input logic [LEN_W-1:0] len);
    int n = 0;
    while (!cfg_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!cfg_ready) chk("cfg_wait", {63'd0, cfg_ready}, 64'd1);
    cfg_valid = 1'b1;
    cfg_mode  = mode;
    cfg_len   = len;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic beat(input logic v, input logic [63:0] a, input logic [63:0] b);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = 64'hA5A5_5A5A_A5A5_5A5A;
    in_b     = 64'h5A5A_A5A5_5A5A_A5A5;
  endtask

  // Called just after the last beat edge E: DRAIN then DONE.
  task automatic check_latency(input string tag);
    @(negedge clk);
    chk({tag, "_drain_out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_drain_in_ready"}, {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    chk({tag, "_done_out_valid"}, {63'd0, out_valid}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] r1;
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_mode  = 1'b0;
    cfg_len   = '0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cfg_ready", {63'd0, cfg_ready}, 64'd1);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // INT len=3: lane0 2*3, lanes 1..3 i*-1.
    r1 = {16'hFFF7, 16'hFFFA, 16'hFFFD, 16'h0012};
    exp_q.push_back(r1);
    do_cfg(1'b0, 8'd3);
    chk("run_in_ready", {63'd0, in_ready}, 64'd1);
    chk("run_busy", {63'd0, busy}, 64'd1);
    repeat (3) beat(1'b1, {16'd3, 16'd2, 16'd1, 16'd2}, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd3});
    check_latency("int3");

    // FP 1.0*1.0 twice, then INT to prove mode relatch and accumulator clear.
    exp_q.push_back(rep(16'h4000));
    do_cfg(1'b1, 8'd2);
    repeat (2) beat(1'b1, rep(16'h3C00), rep(16'h3C00));
    check_latency("fp2");
    exp_q.push_back(rep(16'h7FFF));
    do_cfg(1'b0, 8'd1);
    beat(1'b1, rep(16'h7FFF), rep(16'h0001));
    check_latency("int1");

    // FP mixed lanes: 1*1, 1.5*2, -2*0.5, 65504*2 (overflow to inf).
    exp_q.push_back({16'h7C00, 16'hC000, 16'h4600, 16'h4000});
    do_cfg(1'b1, 8'd2);
    repeat (2) beat(1'b1, {16'h7BFF, 16'hC000, 16'h3E00, 16'h3C00},
                    {16'h4000, 16'h3800, 16'h4000, 16'h3C00});
    check_latency("fpmix");

    // INT wrap.
    exp_q.push_back(rep(16'h8000));
    do_cfg(1'b0, 8'd2);
    beat(1'b1, rep(16'h7FFF), rep(16'h0001));
    beat(1'b1, rep(16'h0001), rep(16'h0001));
    check_latency("wrap");

    // Input gaps and output backpressure.
    exp_q.push_back(r1);
    do_cfg(1'b0, 8'd3);
    beat(1'b1, {16'd3, 16'd2, 16'd1, 16'd2}, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd3});
    chk("gap_in_ready", {63'd0, in_ready}, 64'd1);
    beat(1'b0, rep(16'h1234), rep(16'h4321));
    beat(1'b0, rep(16'h1234), rep(16'h4321));
    beat(1'b1, {16'd3, 16'd2, 16'd1, 16'd2}, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd3});
    beat(1'b1, {16'd3, 16'd2, 16'd1, 16'd2}, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd3});
    out_ready = 1'b0;
    @(negedge clk);
    chk("stall_drain_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    cfg_valid = 1'b1;
    cfg_len   = 8'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_out_data", out_data, r1);
      chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
      chk("hold_cfg_ready", {63'd0, cfg_ready}, 64'd0);
    end
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("after_release_idle", {63'd0, cfg_ready}, 64'd1);

    // Zero-length job: result the cycle after the cfg handshake.
    exp_q.push_back(64'd0);
    do_cfg(1'b0, 8'd0);
    @(negedge clk);
    chk("len0_out_valid", {63'd0, out_valid}, 64'd1);
    chk("len0_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    chk("len0_idle_in_ready", {63'd0, in_ready}, 64'd0);

    // Reset mid-job after 2 of 4 beats.
    do_cfg(1'b0, 8'd4);
    repeat (2) beat(1'b1, rep(16'd5), rep(16'd5));
    rst = 1'b1;
    #1;
    chk("abort_cfg_ready", {63'd0, cfg_ready}, 64'd1);
    chk("abort_in_ready", {63'd0, in_ready}, 64'd0);
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_out_data", out_data, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back(rep(16'h0004));
    do_cfg(1'b0, 8'd1);
    beat(1'b1, rep(16'd2), rep(16'd2));
    check_latency("post_rst");

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
